// File: rtl/decoder_2x4_pkg.sv
// decoder_2x4_pkg
//   Shared widths and the one-hot decode function for the 2-to-4 decoder.
//   Contents:
//     IDX_W       index width (2)
//     OUT_N       number of one-hot outputs (4)
//     ONEHOT_NONE all-zero pattern, used for reset and undefined indices
//     onehot4()   index -> one-hot, ascending range so bit 0 is the leftmost
package decoder_2x4_pkg;

  localparam int IDX_W = 2;
  localparam int OUT_N = 4;

  localparam logic [0:OUT_N-1] ONEHOT_NONE = 4'b0000;

  // An unknown index falls through to the default branch and yields all
  // zeros, so downstream enables are never multi-hot.
  function automatic logic [0:OUT_N-1] onehot4(input logic [IDX_W-1:0] idx);
    logic [0:OUT_N-1] res;
    case (idx)
      2'b00:   res = 4'b1000;
      2'b01:   res = 4'b0100;
      2'b10:   res = 4'b0010;
      2'b11:   res = 4'b0001;
      default: res = ONEHOT_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decoder_2x4_if.sv
// decoder_2x4_if
//   Groups the decoder's index/enable inputs and its decode outputs.
//   Signals:
//     en     decode enable for the registered path
//     w      binary index
//     y      combinational one-hot decode of w
//     y_q    registered one-hot decode (1-cycle latency)
//     y_vld  y_q holds a valid decode
//   Modports:
//     master  control logic: drives en/w, observes the decodes
//     slave   the decoder itself
interface decoder_2x4_if;
  import decoder_2x4_pkg::*;

  logic                en;
  logic [IDX_W-1:0]    w;
  logic [0:OUT_N-1]    y;
  logic [0:OUT_N-1]    y_q;
  logic                y_vld;

  modport master (output en, w, input y, y_q, y_vld);
  modport slave  (input en, w, output y, y_q, y_vld);

endinterface

// File: rtl/decoder_2x4_comb.sv
// decoder_2x4_comb
//   Pure combinational 2-to-4 one-hot decode. Feeds both the glue-logic
//   output y and the D-input of the registered copy in the top.
//   Ports:
//     w  in   [1:0]  binary index
//     y  out  [0:3]  one-hot decode (all zeros for an unknown index)
module decoder_2x4_comb
  import decoder_2x4_pkg::*;
(
  input  logic [IDX_W-1:0] w,
  output logic [0:OUT_N-1] y
);

  always_comb begin
    y = onehot4(w);
  end

endmodule

// File: rtl/decoder_2x4.sv
// decoder_2x4
//   2-to-4 one-hot select/enable generator. y is a same-cycle combinational
//   decode of w; y_q/y_vld are a registered, enable-gated copy for
//   timing-closed consumers.
//   Ports:
//     clk    in     system clock, rising edge
//     rst_n  in     asynchronous active-low reset (y_q=0000, y_vld=0)
//     bus    slave  decoder_2x4_if: en, w in; y, y_q, y_vld out
//   Build option:
//     DECODER_2X4_HOLD_EN  defined: en=0 keeps the last y_q
//                          undefined: en=0 clears y_q to 0000
//     y_vld drops to 0 whenever en=0 in either build.
module decoder_2x4
  import decoder_2x4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  decoder_2x4_if.slave     bus
);

  logic [0:OUT_N-1] y_d;
  logic [0:OUT_N-1] y_q_r;
  logic             y_vld_r;

  decoder_2x4_comb u_comb (
    .w (bus.w),
    .y (y_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r   <= ONEHOT_NONE;
      y_vld_r <= 1'b0;
    end else if (bus.en) begin
      y_q_r   <= y_d;
      y_vld_r <= 1'b1;
    end else begin
`ifdef DECODER_2X4_HOLD_EN
      y_q_r   <= y_q_r;
`else
      y_q_r   <= ONEHOT_NONE;
`endif
      y_vld_r <= 1'b0;
    end
  end

  assign bus.y     = y_d;
  assign bus.y_q   = y_q_r;
  assign bus.y_vld = y_vld_r;

endmodule

// File: tb/tb_decoder_2x4.sv
`timescale 1ns/100ps
module tb_decoder_2x4;

  typedef struct {
    string      name;
    logic [0:3] y;
    logic [0:3] y_q;
    logic       y_vld;
  } exp_t;

  logic clk;
  logic clk_en;
  logic rst_n;

  decoder_2x4_if bus ();

  decoder_2x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   n_cmp;
  int   n_err;

`ifdef DECODER_2X4_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  // Monitor: polls at half-ns offsets so it never samples on a clock edge.
  initial begin
    exp_t e;
    #0.5;
    forever begin
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.y !== e.y) begin
          n_err++;
          $display("FAIL %s y: got %b want %b", e.name, bus.y, e.y);
        end
        n_cmp++;
        if (bus.y_q !== e.y_q) begin
          n_err++;
          $display("FAIL %s y_q: got %b want %b", e.name, bus.y_q, e.y_q);
        end
        n_cmp++;
        if (bus.y_vld !== e.y_vld) begin
          n_err++;
          $display("FAIL %s y_vld: got %b want %b", e.name, bus.y_vld, e.y_vld);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [0:3] y,
                            input logic [0:3] yq, input logic vld);
    exp_t e;
    e.name  = name;
    e.y     = y;
    e.y_q   = yq;
    e.y_vld = vld;
    q.push_back(e);
    for (int i = 0; i < 20 && q.size() > 0; i++) #0.5;
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: monitor did not consume expectation (queue %0d want 0)",
               name, q.size());
      q.delete();
    end
  endtask

  task automatic clk_step(input logic en, input logic [1:0] w);
    @(negedge clk);
    bus.en = en;
    bus.w  = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;

    // w never driven yet: a 4-state simulator sees X and must decode to 0000
    #1;
    if ($isunknown(bus.w)) expect_out("w_x", 4'b0000, 4'b0000, 1'b0);

    // combinational sweep, clock stopped, reset held
    bus.w = 2'b00; #5; expect_out("sweep00", 4'b1000, 4'b0000, 1'b0);
    bus.w = 2'b01; #5; expect_out("sweep01", 4'b0100, 4'b0000, 1'b0);
    bus.w = 2'b10; #5; expect_out("sweep10", 4'b0010, 4'b0000, 1'b0);
    bus.w = 2'b11; #5; expect_out("sweep11", 4'b0001, 4'b0000, 1'b0);

    // clocking under reset with en=1, w=11
    bus.en = 1'b1;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_hold", 4'b0001, 4'b0000, 1'b0);

    // release reset away from an edge, then normal sampling
    @(negedge clk);
    rst_n = 1'b1;
    clk_step(1'b1, 2'b10);
    expect_out("en_w10", 4'b0010, 4'b0010, 1'b1);

    clk_step(1'b0, 2'b01);
    expect_out("en0_w01", 4'b0100, HOLD ? 4'b0010 : 4'b0000, 1'b0);

    clk_step(1'b1, 2'b11);
    expect_out("en_w11", 4'b0001, 4'b0001, 1'b1);

    // mid-cycle w change only moves y
    bus.w = 2'b00;
    #1;
    expect_out("mid_w00", 4'b1000, 4'b0001, 1'b1);

    // asynchronous reset between edges clears at once
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b1000, 4'b0000, 1'b0);

    @(posedge clk);
    #1;
    expect_out("rst_edge", 4'b1000, 4'b0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    clk_step(1'b1, 2'b01);
    expect_out("en_w01", 4'b0100, 4'b0100, 1'b1);

    clk_step(1'b1, 2'b00);
    expect_out("en_w00", 4'b1000, 4'b1000, 1'b1);

    clk_step(1'b1, 2'b10);
    expect_out("en_w10b", 4'b0010, 4'b0010, 1'b1);

    clk_step(1'b0, 2'b11);
    expect_out("en0_w11", 4'b0001, HOLD ? 4'b0010 : 4'b0000, 1'b0);

    clk_step(1'b0, 2'b00);
    expect_out("en0_w00", 4'b1000, HOLD ? 4'b0010 : 4'b0000, 1'b0);

    clk_step(1'b1, 2'b11);
    expect_out("reenable", 4'b0001, 4'b0001, 1'b1);

    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
